alu_share_arb: RTL and testbench

- Shares the single combinational ALU (32-bit operands, 6-bit funct, sign) between two requesters: req0 is the EX stage and req1 is the branch/compare helper.
- Arbitrates the requesters with valid/ready handshakes and drives the ALU from registered operands.
- Captures the ALU result and returns it to the winning requester through a per-requester response handshake.
- One operation is in flight at a time.

---
 rtl/alu_share_arb_if.sv | 32 +++
 rtl/alu_share_arb.sv | 128 ++++++++++++
 tb/tb_alu_share_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arb.
// Bit i of each 2-bit vector belongs to requester i (0 = EX stage, 1 = branch helper).
interface alu_share_arb_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNCT_W = 6
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req_in1_0;
  logic [WIDTH-1:0]   req_in1_1;
  logic [WIDTH-1:0]   req_in2_0;
  logic [WIDTH-1:0]   req_in2_1;
  logic [FUNCT_W-1:0] req_funct_0;
  logic [FUNCT_W-1:0] req_funct_1;
  logic               req_sign_0;
  logic               req_sign_1;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
           req_funct_0, req_funct_1, req_sign_0, req_sign_1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
           req_funct_0, req_funct_1, req_sign_0, req_sign_1, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters, one op in flight at a time.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module alu_share_arb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  alu_share_arb_if.slave     bus,
  output logic [WIDTH-1:0]   alu_in1_o,
  output logic [WIDTH-1:0]   alu_in2_o,
  output logic [FUNCT_W-1:0] alu_funct_o,
  output logic               alu_sign_o,
  input  logic [WIDTH-1:0]   alu_out_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   in1_q, in1_d;
  logic [WIDTH-1:0]   in2_q, in2_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic               any_valid;
  logic               winner;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic rr_ptr_q, rr_ptr_d;
`endif

  // Winner is only meaningful when any_valid is set.
  always_comb begin
    any_valid = |bus.req_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    winner = ~bus.req_valid[0];
`else
    if (&bus.req_valid) begin
      winner = rr_ptr_q;
    end else begin
      winner = ~bus.req_valid[0];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    funct_d    = funct_q;
    sign_d     = sign_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          owner_d           = winner;
          in1_d             = winner ? bus.req_in1_1   : bus.req_in1_0;
          in2_d             = winner ? bus.req_in2_1   : bus.req_in2_0;
          funct_d           = winner ? bus.req_funct_1 : bus.req_funct_0;
          sign_d            = winner ? bus.req_sign_1  : bus.req_sign_0;
          state_d           = StExec;
`ifndef ALU_SHARE_FIXED_PRIO_EN
          rr_ptr_d          = ~winner;
`endif
        end
      end
      StExec: begin
        rsp_data_d = alu_out_i;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      funct_q    <= '0;
      sign_q     <= 1'b0;
      rsp_data_q <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      funct_q    <= funct_d;
      sign_q     <= sign_d;
      rsp_data_q <= rsp_data_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Operand registers hold between grants, so the ALU inputs only move on a grant.
  assign alu_in1_o     = in1_q;
  assign alu_in2_o     = in2_q;
  assign alu_funct_o   = funct_q;
  assign alu_sign_o    = sign_q;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: scoreboard of expected (owner, result) pairs
// pushed on acceptance and popped when a response appears; a small ALU stand-in drives alu_out.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [5:0]  alu_funct;
  logic        alu_sign;
  logic [31:0] alu_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  alu_share_arb_if #(.WIDTH(32), .FUNCT_W(6)) bus ();

  alu_share_arb #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .alu_in1_o   (alu_in1),
    .alu_in2_o   (alu_in2),
    .alu_funct_o (alu_funct),
    .alu_sign_o  (alu_sign),
    .alu_out_i   (alu_out),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: add, sub, and; anything else returns a marker value.
  always_comb begin
    case (alu_funct)
      6'b000000: alu_out = alu_in1 + alu_in2;
      6'b000001: alu_out = alu_in1 - alu_in2;
      6'b011000: alu_out = alu_in1 & alu_in2;
      default:   alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    bus.req_in1_0 = a; bus.req_in2_0 = b; bus.req_funct_0 = f; bus.req_sign_0 = 1'b0;
  endtask

  task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    bus.req_in1_1 = a; bus.req_in2_1 = b; bus.req_funct_1 = f; bus.req_sign_1 = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++;
      $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++;
      $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 32'h0) begin n_err++;
      $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    n_cmp++; if ({alu_in1, alu_in2, alu_funct, alu_sign} !== 71'h0) begin n_err++;
      $display("FAIL reset_alu_ops: got %h %h %b %b want zeros", alu_in1, alu_in2, alu_funct,
               alu_sign); end
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    @(posedge clk); #1;
    set_req0(32'd5, 32'd7, 6'b000000);
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++;
      $display("FAIL single_accept: req_ready=%b want 01", bus.req_ready); end
    exp_q.push_back('{own: 2'b01, data: 32'd12});
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin n_err++;
      $display("FAIL single_exec_ops: in1=%0d in2=%0d want 5 7", alu_in1, alu_in2); end
    n_cmp++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b1) begin n_err++;
      $display("FAIL single_exec_state: rsp_valid=%b busy=%b want 00 1", bus.rsp_valid, busy); end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
      $display("FAIL single_rsp: got %b/%0d want %b/%0d", bus.rsp_valid, bus.rsp_data, e.own,
               e.data); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin n_err++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b want 0 00", busy, bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int grants;
    int rsps;
    logic [1:0] want;
    do_reset();
    set_req0(32'd10, 32'd3, 6'b000001);
    set_req1(32'h0000_00F0, 32'h0000_003C, 6'b011000);
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    grants = 0; rsps = 0;
    for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        want = 2'b01;
`else
        want = (grants % 2 == 0) ? 2'b01 : 2'b10;
`endif
        n_cmp++; if (bus.req_ready !== want) begin n_err++;
          $display("FAIL rr_grant%0d: req_ready=%b want %b", grants, bus.req_ready, want); end
        exp_q.push_back('{own: bus.req_ready,
                          data: (bus.req_ready == 2'b01) ? 32'd7 : 32'h30});
        grants++;
      end
      if (bus.rsp_valid !== 2'b00) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rr_rsp%0d: rsp_valid=%b with nothing expected", rsps, bus.rsp_valid);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
            $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", rsps, bus.rsp_valid, bus.rsp_data,
                     e.own, e.data); end
        end
        rsps++;
      end
    end
    n_cmp++; if (rsps != 4) begin n_err++;
      $display("FAIL rr_timeout: responses=%0d want 4", rsps); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    set_req0(32'h1111_0000, 32'h0000_2222, 6'b000000);
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++;
      $display("FAIL bp_accept: req_ready=%b want 01", bus.req_ready); end
    exp_q.push_back('{own: 2'b01, data: 32'h1111_2222});
    @(posedge clk); #1;
    set_req1(32'd100, 32'd23, 6'b000000);
    bus.req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++;
      $display("FAIL bp_exec_ready: req_ready=%b want 00", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_data, bus.req_ready, busy} !== {2'b01, 32'h1111_2222, 2'b00, 1'b1})
      begin n_err++;
        $display("FAIL bp_stall%0d: rsp_valid=%b data=%h req_ready=%b busy=%b", i, bus.rsp_valid,
                 bus.rsp_data, bus.req_ready, busy); end
    end
    @(posedge clk); #1 bus.rsp_ready = 2'b01;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
      $display("FAIL bp_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, e.own, e.data);
    end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin n_err++;
      $display("FAIL bp_next_grant: rsp_valid=%b req_ready=%b want 00 10", bus.rsp_valid,
               bus.req_ready); end
    exp_q.push_back('{own: 2'b10, data: 32'd123});
    @(posedge clk); #1 bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
      $display("FAIL bp_rsp2: got %b/%0d want %b/%0d", bus.rsp_valid, bus.rsp_data, e.own,
               e.data); end
    @(posedge clk);
  endtask

  task automatic test_wrong_owner();
    @(posedge clk); #1;
    set_req1(32'h1234, 32'h5678, 6'b111111);
    bus.req_valid = 2'b10; bus.rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++;
      $display("FAIL wo_accept: req_ready=%b want 10", bus.req_ready); end
    exp_q.push_back('{own: 2'b10, data: 32'hDEAD_BEEF});
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 2'b10 || busy !== 1'b1) begin n_err++;
        $display("FAIL wo_hold%0d: rsp_valid=%b busy=%b want 10 1", i, bus.rsp_valid, busy); end
    end
    @(posedge clk); #1 bus.rsp_ready = 2'b10;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
      $display("FAIL wo_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, e.own, e.data);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL wo_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    set_req0(32'd10, 32'd3, 6'b000001);
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b11;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++;
      $display("FAIL rst_accept: req_ready=%b want 01", bus.req_ready); end
    @(posedge clk); #1;
    set_req1(32'h0000_00F0, 32'h0000_003C, 6'b011000);
    bus.req_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || alu_funct !== 6'b000001) begin n_err++;
      $display("FAIL rst_exec: busy=%b funct=%b want 1 000001", busy, alu_funct); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.rsp_valid, busy, alu_funct, alu_in1} !== {2'b00, 1'b0, 6'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rst_abort: rsp_valid=%b busy=%b funct=%b in1=%h want 00 0 0 0", bus.rsp_valid,
               busy, alu_funct, alu_in1); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++;
      $display("FAIL rst_regrant: req_ready=%b want 10", bus.req_ready); end
    exp_q.push_back('{own: 2'b10, data: 32'h30});
    @(posedge clk); #1 bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {e.own, e.data}) begin n_err++;
      $display("FAIL rst_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, e.own, e.data);
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req0(32'h0, 32'h0, 6'b0);
    set_req1(32'h0, 32'h0, 6'b0);
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_wrong_owner();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
